// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
// Contents:
//   - FSM state encoding.
//   - Instruction class encoding.
//   - Opcode and extension field constants.
//   - Condition code constants and PSR flag bit positions.
//   - classify(): maps an instruction word to its control-flow class.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_SEQ   = 2'd0,
    CLS_BCOND = 2'd1,
    CLS_JCOND = 2'd2,
    CLS_JAL   = 2'd3
  } instr_cls_e;

  // Opcode field ir[15:12] and extension field ir[7:4]
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_JUMP   = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;

  // Condition codes carried in ir[11:8]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // PSR flag positions {C,L,F,Z,N}
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  function automatic instr_cls_e classify(input logic [15:0] word);
    instr_cls_e cls;
    if (word[15:12] == OP_BCOND) begin
      cls = CLS_BCOND;
    end else if ((word[15:12] == OP_JUMP) && (word[7:4] == EXT_JCOND)) begin
      cls = CLS_JCOND;
    end else if ((word[15:12] == OP_JUMP) && (word[7:4] == EXT_JAL)) begin
      cls = CLS_JAL;
    end else begin
      cls = CLS_SEQ;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and its environment.
// Sequencer inputs:
//   - instr     : instruction word from instruction memory.
//   - mem_ready : instr is valid this cycle.
//   - psr       : flags {C,L,F,Z,N}.
//   - stall     : datapath hold.
//   - pc_next   : next-PC result from the PC adder.
// Sequencer outputs:
//   - pc, ir    : architectural PC and instruction register.
//   - mem_rd    : fetch request.
//   - jump_en, branch_en, jal_en : PC adder mode selects.
//   - link_we   : link register write strobe.
//   - state     : current FSM state, for debug.
// The master modport is the sequencer side; the slave modport is the
// datapath/memory side.
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] instr;
  logic             mem_ready;
  logic [4:0]       psr;
  logic             stall;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc;
  logic             mem_rd;
  logic [WIDTH-1:0] ir;
  logic             jump_en;
  logic             branch_en;
  logic             jal_en;
  logic             link_we;
  logic [1:0]       state;

  modport master (
    input  instr, mem_ready, psr, stall, pc_next,
    output pc, mem_rd, ir, jump_en, branch_en, jal_en, link_we, state
  );

  modport slave (
    output instr, mem_ready, psr, stall, pc_next,
    input  pc, mem_rd, ir, jump_en, branch_en, jal_en, link_we, state
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational branch/jump condition evaluator.
// Ports:
//   - cond_i : condition code (ir[11:8]).
//   - psr_i  : flags {C,L,F,Z,N}.
//   - take_o : 1 when the condition holds.
module cond_eval
  import pc_sequencer_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] psr_i,
  output logic       take_o
);

  logic flag_c_s;
  logic flag_l_s;
  logic flag_f_s;
  logic flag_z_s;
  logic flag_n_s;

  assign flag_c_s = psr_i[PSR_C];
  assign flag_l_s = psr_i[PSR_L];
  assign flag_f_s = psr_i[PSR_F];
  assign flag_z_s = psr_i[PSR_Z];
  assign flag_n_s = psr_i[PSR_N];

  // Condition table lookup
  always_comb begin
    take_o = 1'b0;
    case (cond_i)
      COND_EQ: take_o = flag_z_s;
      COND_NE: take_o = ~flag_z_s;
      COND_CS: take_o = flag_c_s;
      COND_CC: take_o = ~flag_c_s;
      COND_HI: take_o = flag_l_s;
      COND_LS: take_o = ~flag_l_s;
      COND_GT: take_o = flag_n_s;
      COND_LE: take_o = ~flag_n_s;
      COND_FS: take_o = flag_f_s;
      COND_FC: take_o = ~flag_f_s;
      COND_LO: take_o = ~flag_l_s & ~flag_z_s;
      COND_HS: take_o = flag_l_s | flag_z_s;
      COND_LT: take_o = ~flag_n_s & ~flag_z_s;
      COND_GE: take_o = flag_n_s | flag_z_s;
      COND_UC: take_o = 1'b1;
      COND_NV: take_o = 1'b0;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Four-state instruction sequencer: FETCH -> DECODE -> EXEC -> UPDATE.
// Ports:
//   - clk, reset : single clock; synchronous active-high reset.
//   - bus        : pc_sequencer_if master modport carrying all fetch,
//                  flag, stall and PC adder control signals.
// PC arithmetic lives in the external PC adder; this block only loads
// pc from pc_next in UPDATE.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             take_q, take_d;
  logic             mem_rd_q, mem_rd_d;
  logic             jump_en_q, jump_en_d;
  logic             branch_en_q, branch_en_d;
  logic             jal_en_q, jal_en_d;
  logic             link_we_q, link_we_d;

  instr_cls_e       cls_s;
  logic             cond_take_s;

  assign cls_s = classify(ir_q[15:0]);

  // Flags are consumed only while in DECODE, so later psr changes are ignored
  cond_eval u_cond_eval (
    .cond_i (ir_q[11:8]),
    .psr_i  (bus.psr),
    .take_o (cond_take_s)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    take_d      = take_q;
    mem_rd_d    = mem_rd_q;
    jump_en_d   = jump_en_q;
    branch_en_d = branch_en_q;
    jal_en_d    = jal_en_q;
    link_we_d   = link_we_q;
    if (bus.stall) begin
      // Stall freezes everything, including a FETCH that sees mem_ready
      state_d = state_q;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            ir_d     = bus.instr;
            mem_rd_d = 1'b0;
            state_d  = ST_DECODE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          // take flag means "this instruction redirects the PC"
          take_d      = (cls_s == CLS_JAL) |
                        (((cls_s == CLS_BCOND) | (cls_s == CLS_JCOND)) & cond_take_s);
          jal_en_d    = (cls_s == CLS_JAL);
          jump_en_d   = (cls_s == CLS_JCOND) & cond_take_s;
          branch_en_d = (cls_s == CLS_BCOND) & cond_take_s;
          state_d     = ST_EXEC;
        end
        ST_EXEC: begin
          link_we_d = jal_en_q & take_q;
          state_d   = ST_UPDATE;
        end
        ST_UPDATE: begin
          pc_d        = bus.pc_next;
          take_d      = 1'b0;
          jump_en_d   = 1'b0;
          branch_en_d = 1'b0;
          jal_en_d    = 1'b0;
          link_we_d   = 1'b0;
          mem_rd_d    = 1'b1;
          state_d     = ST_FETCH;
        end
        default: begin
          take_d      = 1'b0;
          jump_en_d   = 1'b0;
          branch_en_d = 1'b0;
          jal_en_d    = 1'b0;
          link_we_d   = 1'b0;
          mem_rd_d    = 1'b1;
          state_d     = ST_FETCH;
        end
      endcase
    end
  end

  // FSM and output registers; reset overrides stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= {WIDTH{1'b0}};
      ir_q        <= {WIDTH{1'b0}};
      take_q      <= 1'b0;
      mem_rd_q    <= 1'b1;
      jump_en_q   <= 1'b0;
      branch_en_q <= 1'b0;
      jal_en_q    <= 1'b0;
      link_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      take_q      <= take_d;
      mem_rd_q    <= mem_rd_d;
      jump_en_q   <= jump_en_d;
      branch_en_q <= branch_en_d;
      jal_en_q    <= jal_en_d;
      link_we_q   <= link_we_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.jump_en   = jump_en_q;
  assign bus.branch_en = branch_en_q;
  assign bus.jal_en    = jal_en_q;
  // Masked during stall so the link register is written exactly once,
  // on the edge that completes UPDATE
  assign bus.link_we   = link_we_q & ~bus.stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized instructions, checked against a transaction-level model.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_ir;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Condition table, bit index = condition code; flags {C,L,F,Z,N}
  function automatic bit ref_cond(input logic [3:0] c, input logic [4:0] p);
    bit fc, fl, ff, fz, fn;
    bit [15:0] tbl;
    {fc, fl, ff, fz, fn} = p;
    tbl = {1'b0, 1'b1, fn | fz, !fn & !fz, fl | fz, !fl & !fz, !ff, ff,
           !fn, fn, !fl, fl, !fc, fc, !fz, fz};
    return tbl[c];
  endfunction

  // Expected enable vector {jal, jump, branch}
  function automatic logic [2:0] ref_en(input logic [15:0] w, input logic [4:0] p);
    logic [3:0] top, ext, cnd;
    top = w[15:12];
    ext = w[7:4];
    cnd = w[11:8];
    if (top == 4'hC) return ref_cond(cnd, p) ? 3'b001 : 3'b000;
    if (top == 4'h4 && ext == 4'hC) return ref_cond(cnd, p) ? 3'b010 : 3'b000;
    if (top == 4'h4 && ext == 4'h8) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] en_now();
    return {bus.jal_en, bus.jump_en, bus.branch_en};
  endfunction

  task automatic do_abort();
    reset     = 1'b1;
    bus.stall = 1'b1;
    tick();
    reset     = 1'b0;
    bus.stall = 1'b0;
    exp_pc    = 16'h0000;
    exp_ir    = 16'h0000;
    check_eq("abort_state", {30'd0, bus.state}, 32'd0);
    check_eq("abort_pc", {16'd0, bus.pc}, 32'd0);
    check_eq("abort_ir", {16'd0, bus.ir}, 32'd0);
    check_eq("abort_en", {29'd0, en_now()}, 32'd0);
    check_eq("abort_link", {31'd0, bus.link_we}, 32'd0);
    check_eq("abort_memrd", {31'd0, bus.mem_rd}, 32'd1);
  endtask

  // One instruction; stall_ph 0..3 stalls that phase (other = none);
  // abort_ph 2/3 applies reset in EXEC/UPDATE.
  task automatic run_instr(input logic [15:0] word, input logic [4:0] flags,
                           input int wait_cyc, input int stall_ph, input int stall_len,
                           input logic [15:0] nxt, input int abort_ph);
    logic [2:0] exp_en;
    exp_en      = ref_en(word, flags);
    bus.pc_next = 16'($urandom);
    check_eq("start_state", {30'd0, bus.state}, 32'd0);
    check_eq("start_pc", {16'd0, bus.pc}, {16'd0, exp_pc});
    // FETCH, stall beats mem_ready
    if (stall_ph == 0) begin
      for (int i = 0; i < stall_len; i++) begin
        bus.stall     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.instr     = 16'($urandom);
        tick();
        check_eq("fstall_state", {30'd0, bus.state}, 32'd0);
        check_eq("fstall_ir", {16'd0, bus.ir}, {16'd0, exp_ir});
        check_eq("fstall_memrd", {31'd0, bus.mem_rd}, 32'd1);
      end
    end
    for (int i = 0; i < wait_cyc; i++) begin
      bus.stall     = 1'b0;
      bus.mem_ready = 1'b0;
      bus.instr     = 16'($urandom);
      tick();
      check_eq("wait_state", {30'd0, bus.state}, 32'd0);
      check_eq("wait_memrd", {31'd0, bus.mem_rd}, 32'd1);
      check_eq("wait_ir", {16'd0, bus.ir}, {16'd0, exp_ir});
    end
    bus.stall     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.instr     = word;
    bus.psr       = 5'($urandom);
    tick();
    exp_ir = word;
    check_eq("dec_state", {30'd0, bus.state}, 32'd1);
    check_eq("dec_ir", {16'd0, bus.ir}, {16'd0, word});
    check_eq("dec_memrd", {31'd0, bus.mem_rd}, 32'd0);
    check_eq("dec_en", {29'd0, en_now()}, 32'd0);
    bus.mem_ready = 1'($urandom);
    bus.instr     = 16'($urandom);
    // DECODE
    if (stall_ph == 1) begin
      for (int i = 0; i < stall_len; i++) begin
        bus.stall = 1'b1;
        bus.psr   = 5'($urandom);
        tick();
        check_eq("dstall_state", {30'd0, bus.state}, 32'd1);
      end
    end
    bus.stall = 1'b0;
    bus.psr   = flags;
    tick();
    check_eq("exec_state", {30'd0, bus.state}, 32'd2);
    check_eq("exec_en", {29'd0, en_now()}, {29'd0, exp_en});
    check_eq("exec_link", {31'd0, bus.link_we}, 32'd0);
    check_eq("exec_memrd", {31'd0, bus.mem_rd}, 32'd0);
    bus.psr = 5'($urandom);
    // EXEC
    if (abort_ph == 2) begin
      do_abort();
      return;
    end
    if (stall_ph == 2) begin
      for (int i = 0; i < stall_len; i++) begin
        bus.stall = 1'b1;
        tick();
        check_eq("estall_state", {30'd0, bus.state}, 32'd2);
        check_eq("estall_en", {29'd0, en_now()}, {29'd0, exp_en});
        check_eq("estall_pc", {16'd0, bus.pc}, {16'd0, exp_pc});
      end
    end
    bus.stall = 1'b0;
    tick();
    check_eq("upd_state", {30'd0, bus.state}, 32'd3);
    check_eq("upd_en", {29'd0, en_now()}, {29'd0, exp_en});
    check_eq("upd_pc", {16'd0, bus.pc}, {16'd0, exp_pc});
    check_eq("upd_memrd", {31'd0, bus.mem_rd}, 32'd0);
    // UPDATE
    if (abort_ph == 3) begin
      do_abort();
      return;
    end
    if (stall_ph == 3) begin
      for (int i = 0; i < stall_len; i++) begin
        bus.stall   = 1'b1;
        bus.pc_next = 16'($urandom);
        #1;
        check_eq("ustall_link", {31'd0, bus.link_we}, 32'd0);
        tick();
        check_eq("ustall_state", {30'd0, bus.state}, 32'd3);
        check_eq("ustall_en", {29'd0, en_now()}, {29'd0, exp_en});
        check_eq("ustall_pc", {16'd0, bus.pc}, {16'd0, exp_pc});
      end
    end
    bus.stall   = 1'b0;
    bus.pc_next = nxt;
    #1;
    check_eq("upd_link", {31'd0, bus.link_we}, {31'd0, exp_en[2]});
    tick();
    exp_pc = nxt;
    check_eq("done_state", {30'd0, bus.state}, 32'd0);
    check_eq("done_pc", {16'd0, bus.pc}, {16'd0, exp_pc});
    check_eq("done_en", {29'd0, en_now()}, 32'd0);
    check_eq("done_link", {31'd0, bus.link_we}, 32'd0);
    check_eq("done_memrd", {31'd0, bus.mem_rd}, 32'd1);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] r;
    int          cls;
    int          sph;
    int          aph;
    reset         = 1'b1;
    bus.instr     = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.psr       = 5'd0;
    bus.stall     = 1'b1;
    bus.pc_next   = 16'h1234;
    tick();
    tick();
    check_eq("rst_state", {30'd0, bus.state}, 32'd0);
    check_eq("rst_pc", {16'd0, bus.pc}, 32'd0);
    check_eq("rst_ir", {16'd0, bus.ir}, 32'd0);
    check_eq("rst_en", {29'd0, en_now()}, 32'd0);
    check_eq("rst_link", {31'd0, bus.link_we}, 32'd0);
    reset     = 1'b0;
    bus.stall = 1'b0;
    exp_pc    = 16'h0000;
    exp_ir    = 16'h0000;

    // Sequential stream including PC wrap
    run_instr(16'h0000, 5'd0, 0, 9, 0, 16'h0002, 0);
    run_instr(16'h0000, 5'd0, 0, 9, 0, 16'hFFFF, 0);
    run_instr(16'h0000, 5'd0, 0, 9, 0, 16'h0000, 0);
    // Bcond EQ taken / not taken
    run_instr(16'hC005, 5'b00010, 0, 9, 0, 16'h0010, 0);
    run_instr(16'hC005, 5'b00000, 0, 9, 0, 16'h0012, 0);
    // Jcond LO taken, L=1 not taken, cond F never
    run_instr(16'h4AC3, 5'b00000, 0, 9, 0, 16'h0020, 0);
    run_instr(16'h4AC3, 5'b01000, 0, 9, 0, 16'h0022, 0);
    run_instr(16'h4FC3, 5'b11111, 0, 9, 0, 16'h0024, 0);
    // JAL
    run_instr(16'h4582, 5'd0, 0, 9, 0, 16'h0040, 0);
    // 3-cycle EXEC stall, 5-cycle memory delay, stall during fetch hit
    run_instr(16'hC005, 5'b00010, 0, 2, 3, 16'h0050, 0);
    run_instr(16'h0000, 5'd0, 5, 9, 0, 16'h0052, 0);
    run_instr(16'h4582, 5'd0, 1, 0, 2, 16'h0054, 0);
    run_instr(16'h4582, 5'd0, 0, 3, 3, 16'h0056, 0);
    // Reset in UPDATE of a JAL, then resume from 0
    run_instr(16'h4582, 5'd0, 0, 9, 0, 16'h0060, 3);
    run_instr(16'h0000, 5'd0, 0, 9, 0, 16'h0002, 0);

    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 4);
      r   = 16'($urandom);
      case (cls)
        0: begin
          w = r;
          if (w[15:12] == 4'hC || w[15:12] == 4'h4) w[15:12] = 4'h0;
        end
        1: w = {4'hC, r[11:0]};
        2: w = {4'h4, r[11:8], 4'hC, r[3:0]};
        3: w = {4'h4, r[11:8], 4'h8, r[3:0]};
        default: w = {4'h4, r[11:8], 1'b0, r[6:4], r[3:0]};
      endcase
      sph = $urandom_range(0, 5);
      aph = ($urandom_range(0, 19) == 0) ? $urandom_range(2, 3) : 0;
      run_instr(w, 5'($urandom), $urandom_range(0, 3), sph, $urandom_range(1, 3),
                16'($urandom), aph);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, datapath and PC width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  WIDTH  instruction word returned by instruction memory.
REQ-005 mem_ready  input  1  instr valid this cycle for the outstanding fetch.
REQ-006 psr  input  5  flags {C,L,F,Z,N}, bit 4 = C, bit 0 = N.
REQ-007 stall  input  1  datapath hold; freezes FSM and all registers.
REQ-008 pc_next  input  WIDTH  next-PC result from the PC adder (pcOut).
REQ-009 pc  output  WIDTH  architectural PC register, feeds PC adder and fetch address.
REQ-010 mem_rd  output  1  instruction fetch request.
REQ-011 ir  output  WIDTH  latched instruction register.
REQ-012 jump_en, branch_en, jal_en  output  1 each  PC adder mode selects, mutually exclusive.
REQ-013 link_we  output  1  write strobe for the link register (JAL).
REQ-014 state  output  2  current FSM state, for debug.

Function
REQ-015 FSM states: FETCH=0, DECODE=1, EXEC=2, UPDATE=3.
REQ-016 FETCH: mem_rd=1; on mem_ready=1 latch instr into ir, go DECODE; else remain (unbounded wait).
REQ-017 DECODE: one cycle; classify ir; evaluate condition; register take flag; go EXEC.
REQ-018 Classes: Bcond = ir[15:12]=4'b1100, cond=ir[11:8]; Jcond = ir[15:12]=4'b0100 and ir[7:4]=4'b1100, cond=ir[11:8]; JAL = ir[15:12]=4'b0100 and ir[7:4]=4'b1000; all else sequential.
REQ-019 Cond table: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E UC 1; F never 0.
REQ-020 Condition evaluated on psr sampled in DECODE; psr changes in EXEC have no effect.
REQ-021 EXEC: one cycle; assert exactly one of jal_en (JAL), jump_en (Jcond taken), branch_en (Bcond taken); none for not-taken or sequential; go UPDATE.
REQ-022 Mode selects held stable from EXEC through UPDATE so pc_next is valid when sampled.
REQ-023 UPDATE: pc <= pc_next; link_we=1 for exactly one cycle iff JAL; deassert mode selects next cycle; go FETCH.
REQ-024 PC arithmetic is owned by the PC adder; this block never adds to pc itself; pc wraps naturally modulo 2^WIDTH.
REQ-025 stall=1: state, pc, ir, take flag hold; outputs hold their current values; link_we forced 0 while stalled, reasserted when UPDATE completes.
REQ-026 stall and mem_ready both high in FETCH: stall wins; instr not latched.
REQ-027 Latency: non-stalled instruction = fetch wait + 4 cycles, FETCH to next FETCH.
REQ-028 mem_rd asserted only in FETCH; never in other states.

Reset
REQ-029 reset=1 at a clock edge: state=FETCH, pc=0, ir=0, take flag=0, all enables and link_we=0; reset overrides stall.
REQ-030 Reset mid-instruction abandons it; no pc update or link write occurs; first fetch from address 0 the cycle after reset deasserts.

Structure
REQ-031 Shared package holds state encoding, opcode/ext constants (4'b1100, 4'b0100, 4'b1000) and the condition code constants.
REQ-032 Condition evaluation SHALL be a combinational sub-module cond_eval (cond[3:0], psr[4:0] -> take).

Verification
REQ-033 Reset, mem_ready=1, instr=16'h0000 -> pc loaded from pc_next each UPDATE, state cycles 0,1,2,3,0; no enables asserted.
REQ-034 Bcond EQ (instr=16'hC005), psr Z=1 -> branch_en=1 in EXEC and UPDATE; with Z=0 -> no enable.
REQ-035 Jcond LO (instr=16'h4AC3), psr L=0,Z=0 -> jump_en=1; L=1 -> not taken; cond F -> never taken.
REQ-036 JAL (instr=16'h4582) -> jal_en=1 in EXEC/UPDATE, link_we=1 one cycle in UPDATE, pc=pc_next=16'h0040.
REQ-037 stall=1 for 3 cycles in EXEC -> state, pc, enables hold; completes normally after release; mem_ready delayed 5 cycles -> remains FETCH with mem_rd=1.
REQ-038 reset asserted in UPDATE of a JAL -> link_we=0, pc=0, state=FETCH next cycle.
